// File: rtl/link_ds_param.sv
// link_ds_param -- multi-channel DDR-style link downstream receiver.
//
// Each channel collects two io beats into one 2*width_p flit ({beat1, beat0})
// and pushes it into a private 2^lg_fifo_depth_p entry buffer. The core side
// sees one combined flit that is valid only when every channel has data. A yumi
// pops all channels together. Each channel toggles a credit token every
// 2^lg_token_dec_p dequeues.
//
// Ports:
//   clk             sole clock, posedge
//   rst             async active-high reset
//   io_valid_i      [channels_p]           per-channel beat valid
//   io_data_i       [channels_p*width_p]   per-channel beat, ch c at [c*width_p +: width_p]
//   core_data_o     [2*channels_p*width_p] head flit, ch c at [c*2*width_p +: 2*width_p]
//   core_valid_o    all channel buffers non-empty
//   core_yumi_i     consumer takes head flit (ignored while core_valid_o low)
//   core_token_r_o  [channels_p]           per-channel credit-return toggle
//   err_o           sticky overflow flag
//
// Build option: define LINK_DS_PARAM_OVERFLOW_ERR_EN to make err_o latch on any
// dropped flit. Without it err_o is tied to 0 and no drop detection is built;
// dropping itself still happens.

module link_ds_param_ch #(
  parameter int width_p         = 8,
  parameter int lg_fifo_depth_p = 3,
  parameter int lg_token_dec_p  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic [width_p-1:0]   data_i,
  input  logic                 deq_i,
  output logic [2*width_p-1:0] data_o,
  output logic                 nonempty_o,
  output logic                 token_o,
  output logic                 drop_o
);
  localparam int depth_lp  = 1 << lg_fifo_depth_p;
  localparam int ptr_w_lp  = lg_fifo_depth_p + 1;
  localparam int tcnt_w_lp = (lg_token_dec_p > 0) ? lg_token_dec_p : 1;
  localparam logic [tcnt_w_lp-1:0] tcnt_max_lp = tcnt_w_lp'((1 << lg_token_dec_p) - 1);

  logic                 phase_q, phase_d;
  logic [ptr_w_lp-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [tcnt_w_lp-1:0] tcnt_q, tcnt_d;
  logic                 token_q, token_d;
  logic [width_p-1:0]   beat0_q;
  logic [2*width_p-1:0] mem_q [depth_lp];

  logic full, empty, enq, enq_ok;

  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[lg_fifo_depth_p] != rptr_q[lg_fifo_depth_p]) &&
                  (wptr_q[lg_fifo_depth_p-1:0] == rptr_q[lg_fifo_depth_p-1:0]);
  assign enq    = valid_i & phase_q;
  // A full buffer still accepts when the same edge frees a slot.
  assign enq_ok = enq & (~full | deq_i);

`ifdef LINK_DS_PARAM_OVERFLOW_ERR_EN
  assign drop_o = enq & full & ~deq_i;
`else
  assign drop_o = 1'b0;
`endif

  always_comb begin
    phase_d = phase_q ^ valid_i;
    wptr_d  = wptr_q + ptr_w_lp'(enq_ok);
    rptr_d  = rptr_q + ptr_w_lp'(deq_i);
    tcnt_d  = tcnt_q;
    token_d = token_q;
    if (deq_i) begin
      if (tcnt_q == tcnt_max_lp) begin
        tcnt_d  = '0;
        token_d = ~token_q;
      end else begin
        tcnt_d  = tcnt_q + tcnt_w_lp'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      tcnt_q  <= '0;
      token_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      tcnt_q  <= tcnt_d;
      token_q <= token_d;
    end
  end

  // Datapath storage is not reset; writes are blocked while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && valid_i && !phase_q) beat0_q <= data_i;
    if (!rst && enq_ok) mem_q[wptr_q[lg_fifo_depth_p-1:0]] <= {data_i, beat0_q};
  end

  assign data_o     = mem_q[rptr_q[lg_fifo_depth_p-1:0]];
  assign nonempty_o = ~empty;
  assign token_o    = token_q;
endmodule

module link_ds_param #(
  parameter int width_p         = 8,
  parameter int channels_p      = 2,
  parameter int lg_fifo_depth_p = 3,
  parameter int lg_token_dec_p  = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [channels_p-1:0]           io_valid_i,
  input  logic [channels_p*width_p-1:0]   io_data_i,
  output logic [2*channels_p*width_p-1:0] core_data_o,
  output logic                            core_valid_o,
  input  logic                            core_yumi_i,
  output logic [channels_p-1:0]           core_token_r_o,
  output logic                            err_o
);
  logic [channels_p-1:0]                nonempty;
  logic [channels_p-1:0]                drop;
  logic [channels_p-1:0][2*width_p-1:0] flit;
  logic                                 deq;

  assign core_valid_o = &nonempty;
  assign deq          = core_yumi_i & core_valid_o;
  assign core_data_o  = flit;

  link_ds_param_ch #(
    .width_p        (width_p),
    .lg_fifo_depth_p(lg_fifo_depth_p),
    .lg_token_dec_p (lg_token_dec_p)
  ) u_ch [channels_p-1:0] (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (io_valid_i),
    .data_i    (io_data_i),
    .deq_i     (deq),
    .data_o    (flit),
    .nonempty_o(nonempty),
    .token_o   (core_token_r_o),
    .drop_o    (drop)
  );

`ifdef LINK_DS_PARAM_OVERFLOW_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (|drop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err_o = err_q;
`else
  logic unused_drop;
  assign unused_drop = |drop;
  assign err_o       = 1'b0;
`endif
endmodule

// File: tb/tb_link_ds_param.sv
// Self-checking bench for link_ds_param (default parameters). A queue-based
// reference model tracks per-channel flits, phases, token counts and the
// overflow flag; directed scenarios are followed by a randomized run.

module tb_link_ds_param;
  localparam int W     = 8;
  localparam int CH    = 2;
  localparam int LGD   = 3;
  localparam int LGT   = 1;
  localparam int DEPTH = 1 << LGD;
`ifdef LINK_DS_PARAM_OVERFLOW_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [CH-1:0]       io_valid_i = '0;
  logic [CH*W-1:0]     io_data_i = '0;
  logic [2*CH*W-1:0]   core_data_o;
  logic                core_valid_o;
  logic                core_yumi_i = 1'b0;
  logic [CH-1:0]       core_token_r_o;
  logic                err_o;

  link_ds_param #(
    .width_p(W), .channels_p(CH), .lg_fifo_depth_p(LGD), .lg_token_dec_p(LGT)
  ) dut (
    .clk(clk), .rst(rst), .io_valid_i(io_valid_i), .io_data_i(io_data_i),
    .core_data_o(core_data_o), .core_valid_o(core_valid_o), .core_yumi_i(core_yumi_i),
    .core_token_r_o(core_token_r_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [2*W-1:0] mq [CH][$];
  bit             m_ph  [CH];
  logic [W-1:0]   m_b0  [CH];
  int             m_tc  [CH];
  logic [CH-1:0]  m_tok;
  bit             m_err;

  function automatic bit m_valid();
    for (int c = 0; c < CH; c++) if (mq[c].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [2*CH*W-1:0] m_head();
    logic [2*CH*W-1:0] h = '0;
    for (int c = 0; c < CH; c++) h[c*2*W +: 2*W] = mq[c][0];
    return h;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < CH; c++) begin
      mq[c].delete();
      m_ph[c] = 1'b0;
      m_tc[c] = 0;
    end
    m_tok = '0;
    m_err = 1'b0;
  endtask

  task automatic m_step(input logic [CH-1:0] v, input logic [CH*W-1:0] d, input logic y);
    bit acc = y && m_valid();
    for (int c = 0; c < CH; c++) begin
      if (acc) begin
        void'(mq[c].pop_front());
        m_tc[c] = (m_tc[c] + 1) % (1 << LGT);
        if (m_tc[c] == 0) m_tok[c] = ~m_tok[c];
      end
      if (v[c]) begin
        if (!m_ph[c]) m_b0[c] = d[c*W +: W];
        else if (mq[c].size() < DEPTH) mq[c].push_back({d[c*W +: W], m_b0[c]});
        else if (ERR_EN) m_err = 1'b1;
        m_ph[c] = ~m_ph[c];
      end
    end
  endtask

  task automatic check_outs();
    check("valid", 64'(core_valid_o), 64'(m_valid()));
    if (m_valid()) check("data", 64'(core_data_o), 64'(m_head()));
    check("token", 64'(core_token_r_o), 64'(m_tok));
    check("err", 64'(err_o), 64'(m_err));
  endtask

  // One clock: inputs applied at negedge, model stepped at posedge, checks at next negedge.
  task automatic cyc(input logic [CH-1:0] v, input logic [CH*W-1:0] d, input logic y);
    io_valid_i  = v;
    io_data_i   = d;
    core_yumi_i = y;
    @(posedge clk);
    m_step(v, d, y);
    @(negedge clk);
    check_outs();
  endtask

  // Asserted mid-cycle with live inputs to confirm the async path and that a
  // reset edge neither enqueues nor dequeues.
  task automatic do_reset();
    io_valid_i  = '1;
    io_data_i   = 16'h5A5A;
    core_yumi_i = 1'b1;
    rst = 1'b1;
    #1;
    check("rst_valid", 64'(core_valid_o), 64'd0);
    check("rst_token", 64'(core_token_r_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    io_valid_i  = '0;
    core_yumi_i = 1'b0;
    #1;
    check_outs();
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      cyc('1, CH*W'($urandom), 1'b0);
      cyc('1, CH*W'($urandom), 1'b0);
    end
  endtask

  logic [2*CH*W-1:0] exp_head;

  initial begin
    @(negedge clk);
    do_reset();

    // Two-channel single flit
    cyc(2'b11, 16'h3311, 1'b0);
    cyc(2'b11, 16'h4422, 1'b0);
    check("r032_valid", 64'(core_valid_o), 64'd1);
    check("r032_data", 64'(core_data_o), 64'h4433_2211);

    // Skewed channels: ch0 ahead, ch1 catches up
    do_reset();
    for (int i = 0; i < 4; i++) cyc(2'b01, CH*W'($urandom), 1'b0);
    check("r033_wait", 64'(core_valid_o), 64'd0);
    cyc(2'b10, CH*W'($urandom), 1'b0);
    check("r033_half", 64'(core_valid_o), 64'd0);
    cyc(2'b10, CH*W'($urandom), 1'b0);
    check("r033_valid", 64'(core_valid_o), 64'd1);

    // Token toggling every second dequeue
    do_reset();
    fill(DEPTH);
    for (int i = 0; i < 4; i++) begin
      cyc('0, '0, 1'b1);
      if (i == 0) check("r034_tok1", 64'(core_token_r_o), 64'h0);
      if (i == 1) check("r034_tok2", 64'(core_token_r_o), 64'h3);
      if (i == 3) check("r034_tok4", 64'(core_token_r_o), 64'h0);
    end

    // Overflow without yumi: flit dropped
    do_reset();
    fill(DEPTH);
    exp_head = m_head();
    cyc('1, 16'hEEEE, 1'b0);
    cyc('1, 16'hFFFF, 1'b0);
    check("r035_err", 64'(err_o), 64'(ERR_EN));
    check("r035_head", 64'(core_data_o), 64'(exp_head));
    for (int i = 0; i < DEPTH; i++) cyc('0, '0, 1'b1);
    check("r035_drained", 64'(core_valid_o), 64'd0);

    // Full buffer, ninth flit completes with yumi: accepted
    do_reset();
    fill(DEPTH);
    cyc('1, 16'h1234, 1'b0);
    cyc('1, 16'h5678, 1'b1);
    check("r036_err", 64'(err_o), 64'd0);
    for (int i = 0; i < DEPTH - 1; i++) cyc('0, '0, 1'b1);
    check("r036_last", 64'(core_valid_o), 64'd1);
    check("r036_lastdata", 64'(core_data_o), 64'h5612_7834);
    cyc('0, '0, 1'b1);
    check("r036_empty", 64'(core_valid_o), 64'd0);

    // Reset between beats discards the partial flit
    do_reset();
    cyc('1, 16'h1111, 1'b0);
    do_reset();
    cyc('1, 16'hCCAA, 1'b0);
    cyc('1, 16'hDDBB, 1'b0);
    check("r037_valid", 64'(core_valid_o), 64'd1);
    check("r037_data", 64'(core_data_o), 64'hDDCC_BBAA);

    // Randomized: fill-biased phase, then drain-biased phase
    do_reset();
    for (int i = 0; i < 800; i++) begin
      int yprob = (i < 400) ? 25 : 75;
      if ($urandom_range(0, 249) == 0) do_reset();
      else cyc(CH'($urandom), CH*W'($urandom), ($urandom_range(0, 99) < yprob));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/link_ds_param.md
LINK_DS_PARAM -- requirements
Module: link_ds_param

Interface
REQ-001 SHALL provide parameter width_p, default 8, bits per channel per IO beat.
REQ-002 SHALL provide parameter channels_p, default 2, number of independent IO channels.
REQ-003 SHALL provide parameter lg_fifo_depth_p, default 3, log2 of per-channel flit buffer depth.
REQ-004 SHALL provide parameter lg_token_dec_p, default 1, log2 of dequeues per token toggle.
REQ-005 SHALL provide: clk  in  1  sole clock; all state on posedge.
REQ-006 SHALL provide: rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL provide: io_valid_i  in  channels_p  per-channel beat valid.
REQ-008 SHALL provide: io_data_i  in  channels_p*width_p  per-channel beat data, channel c at bits [c*width_p +: width_p].
REQ-009 SHALL provide: core_data_o  out  2*channels_p*width_p  head flit, channel c at bits [c*2*width_p +: 2*width_p].
REQ-010 SHALL provide: core_valid_o  out  1  all channel buffers non-empty.
REQ-011 SHALL provide: core_yumi_i  in  1  consumer takes head flit this cycle.
REQ-012 SHALL provide: core_token_r_o  out  channels_p  per-channel credit-return toggle.
REQ-013 SHALL provide: err_o  out  1  sticky overflow flag.

Function
REQ-014 Each channel SHALL keep a 1-bit phase, toggled on every cycle its io_valid_i is high.
REQ-015 Phase 0 beat SHALL be held in a per-channel low-half register; phase 1 beat forms high half; flit = {beat1, beat0}.
REQ-016 A flit SHALL be enqueued into its channel buffer on the same edge that captures beat 1.
REQ-017 Buffer SHALL be 2^lg_fifo_depth_p entries, binary read/write pointers one bit wider than address, wrap-around by natural overflow.
REQ-018 Full = pointers equal except MSB; empty = pointers equal; both derived from registered pointers.
REQ-019 core_valid_o SHALL be the AND of all channel non-empty flags; a flit enqueued at edge N SHALL produce core_valid_o high from cycle N+1 (one-cycle latency).
REQ-020 core_data_o SHALL be the combinational read of each channel's head entry; undefined content permitted when core_valid_o is low.
REQ-021 core_yumi_i with core_valid_o high SHALL advance every channel read pointer by one; core_yumi_i with core_valid_o low SHALL be ignored.
REQ-022 Enqueue on a full channel with simultaneous accepted yumi SHALL succeed (no overflow).
REQ-023 Enqueue on a full channel without accepted yumi SHALL drop the flit; pointers unchanged; phase still toggles.
REQ-024 Each channel SHALL count its dequeues modulo 2^lg_token_dec_p; on wrap to 0 core_token_r_o[c] SHALL toggle at that edge.
REQ-025 Channels SHALL be independent in phase and buffer occupancy; skew between channels SHALL be tolerated up to buffer depth.

Reset
REQ-026 On rst asserted, immediately and without clk: phases 0, pointers 0, token counters 0, core_token_r_o all 0, err_o 0, core_valid_o 0.
REQ-027 Beat-0 and buffer data registers SHALL NOT be reset.
REQ-028 rst asserted mid-flit SHALL discard the partial beat; first valid beat after deassertion is phase 0.
REQ-029 No enqueue, dequeue or token toggle SHALL occur on an edge where rst is high.

Configuration
REQ-030 Macro LINK_DS_PARAM_OVERFLOW_ERR_EN defined: err_o SHALL set on the edge of any REQ-023 drop and hold until rst.
REQ-031 Macro undefined: err_o SHALL be constant 0 and no overflow-detect logic SHALL be present; drop behaviour of REQ-023 unchanged.

Verification (width_p=8, channels_p=2, lg_fifo_depth_p=3, lg_token_dec_p=1)
REQ-032 Both channels beats 0x11,0x22 (ch0) and 0x33,0x44 (ch1) on consecutive cycles -> next cycle core_valid_o=1, core_data_o=0x4433_2211.
REQ-033 Ch0 sends 2 flits, ch1 none -> core_valid_o stays 0; ch1 then sends 1 flit -> core_valid_o=1 one cycle later.
REQ-034 Fill 8 flits both channels, yumi held 4 cycles -> core_token_r_o toggles 0->1 after 2nd yumi, 1->0 after 4th.
REQ-035 Full buffer, 9th flit with yumi=0 -> flit dropped, err_o=1 (macro defined) / err_o=0 (undefined); head flit unchanged.
REQ-036 Full buffer, 9th flit completing same cycle as yumi -> accepted, occupancy stays 8, err_o=0.
REQ-037 rst pulsed between beat 0 and beat 1 -> core_valid_o=0 immediately; following two beats 0xAA,0xBB form flit 0xBBAA.
